// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM state, ifmap tag positions, config struct and config sanitiser
// for the pe_multi_fil processing element.
package pe_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_MAC, ST_PUSH, ST_ADV} state_t;
    // tag bits sit just above the data value: bit DW+EOR_OFS and bit DW+SOR_OFS
    localparam int EOR_OFS = 0;
    localparam int SOR_OFS = 1;
    typedef struct packed {
        logic [7:0] stride;
        logic [7:0] fs;
        logic [7:0] n_fil;
    } cfg_t;
    function automatic cfg_t sanitize(input logic [7:0] stride, input logic [7:0] fs, input logic [7:0] n_fil,
                                      input logic [7:0] fs_max, input logic [7:0] nf_max);
        cfg_t c;
        c.stride = (stride == 8'd0) ? 8'd1 : stride;
        c.fs = (fs == 8'd0) ? 8'd1 : (fs > fs_max) ? fs_max : fs;
        c.n_fil = (n_fil == 8'd0) ? 8'd1 : (n_fil > nf_max) ? nf_max : n_fil;
        return c;
    endfunction
endpackage

// File: rtl/pe_fifo.sv
// pe_fifo: synchronous FIFO with full/empty flags and a combinational head read.
module pe_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign full = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;
    assign w_push = push && !full;
    assign w_pop = pop && !empty;
    assign dout = r_mem[r_rp];
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= din;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == AW'(DEPTH-1)) ? '0 : r_wp + AW'(1);
            if (w_pop) r_rp <= (r_rp == AW'(DEPTH-1)) ? '0 : r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/pe_multi_fil.sv
// pe_multi_fil: 1D-convolution PE with multi-filter scratchpad, strided windows and psum FIFO.
// Define PE_SAT_EN to saturate psums instead of wrapping them to the low DATA_WIDTH bits.
module pe_multi_fil
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH_IFM = 4,
    parameter int FIL_DEPTH = 15,
    parameter int NUM_FIL = 4,
    parameter int OUT_DEPTH = 8,
    parameter int S = 3,
    parameter int F = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [S-1:0]              stride,
    input  logic [F-1:0]              filter_size,
    input  logic [$clog2(NUM_FIL):0]  n_fil,
    input  logic                      w_en_ifm,
    input  logic [DATA_WIDTH+1:0]     data_in_ifm,
    output logic                      ready_ifm,
    input  logic                      w_en_fil,
    input  logic [DATA_WIDTH-1:0]     data_in_fil,
    output logic                      ready_fil,
    input  logic                      r_en,
    output logic [DATA_WIDTH-1:0]     out,
    output logic                      valid,
    output logic                      done
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH_IFM;
    localparam int DEPTH = 1 << AW;
    localparam int FN = NUM_FIL * FIL_DEPTH;
    localparam int FA = $clog2(FN);
    localparam int ACW = 2 * DW + $clog2(FIL_DEPTH + 1);
    localparam int EOR = DW + EOR_OFS;

    state_t r_state;
    cfg_t r_cfg, w_cfg;
    logic [DW:0] r_ifm [DEPTH];
    logic [DW-1:0] r_fil [FN];
    logic [AW-1:0] r_wp, r_hd;
    logic [AW:0] r_cnt;
    logic [FA-1:0] r_fcnt, r_ftot, r_fbase;
    logic [7:0] r_tap, r_fi;
    logic signed [ACW-1:0] r_acc;
    logic r_ready_fil, r_valid;
    logic [DW-1:0] r_out;
    logic w_wr, w_fwr, w_eor_any, w_disc, w_mac, w_eor_adv, w_adv, w_push, w_full, w_empty, w_pop;
    logic [7:0] w_eor_pos, w_cnt, w_free;
    logic [DW-1:0] w_head, w_psum, w_fifo_dout;
    logic signed [2*DW-1:0] w_a, w_b, w_prod;
    logic w_unused_sor;

    assign w_unused_sor = data_in_ifm[DW+SOR_OFS];
    assign w_cfg = sanitize(8'(stride), 8'(filter_size), 8'(n_fil), 8'(FIL_DEPTH), 8'(NUM_FIL));
    assign w_cnt = 8'(r_cnt);
    assign ready_ifm = (r_state != ST_IDLE) && (r_cnt != (AW+1)'(DEPTH));
    assign ready_fil = r_ready_fil;
    assign out = r_out;
    assign valid = r_valid;
    assign w_wr = w_en_ifm && ready_ifm;
    assign w_fwr = w_en_fil && r_ready_fil;
    assign w_pop = r_en && !w_empty;

    // first end-of-row among the buffered entries, counted from head
    always_comb begin
        w_eor_any = 1'b0;
        w_eor_pos = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (8'(i) < w_cnt && r_ifm[r_hd + AW'(i)][EOR]) begin
                w_eor_any = 1'b1;
                w_eor_pos = 8'(i);
            end
    end

    assign w_disc = (r_state == ST_WAIT) && !r_ready_fil && w_eor_any && (w_eor_pos + 8'd1 < r_cfg.fs);
    assign w_mac = (r_state == ST_WAIT) && !r_ready_fil && !w_disc && (w_cnt >= r_cfg.fs);
    assign w_eor_adv = w_eor_any && (w_eor_pos < r_cfg.stride);
    // an advance whose stride reaches beyond the buffered data waits for it to arrive
    assign w_adv = (r_state == ST_ADV) && (w_eor_adv || w_cnt >= r_cfg.stride);
    assign w_free = w_disc ? w_eor_pos + 8'd1 : !w_adv ? 8'd0 : w_eor_adv ? w_eor_pos + 8'd1 : r_cfg.stride;
    assign done = w_disc || (w_adv && w_eor_adv);
    assign w_push = (r_state == ST_PUSH) && !w_full;

    assign w_head = r_ifm[r_hd + AW'(r_tap)][DW-1:0];
    assign w_a = (2*DW)'($signed(w_head));
    assign w_b = (2*DW)'($signed(r_fil[r_fbase + FA'(r_tap)]));
    assign w_prod = w_a * w_b;

`ifdef PE_SAT_EN
    localparam logic signed [ACW-1:0] SMAX = {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACW-1:0] SMIN = ~SMAX;
    assign w_psum = (r_acc > SMAX) ? SMAX[DW-1:0] : (r_acc < SMIN) ? SMIN[DW-1:0] : r_acc[DW-1:0];
`else
    assign w_psum = r_acc[DW-1:0];
`endif

    pe_fifo #(.W(DW), .DEPTH(OUT_DEPTH)) u_ofifo (
        .clk(clk), .rst_n(rst_n), .push(w_push), .din(w_psum),
        .pop(w_pop), .dout(w_fifo_dout), .full(w_full), .empty(w_empty)
    );

    always_ff @(posedge clk) begin
        if (w_wr) r_ifm[r_wp] <= data_in_ifm[DW:0];
        if (w_fwr) r_fil[r_fcnt] <= data_in_fil;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cfg <= '0;
            r_wp <= '0;
            r_hd <= '0;
            r_cnt <= '0;
            r_fcnt <= '0;
            r_ftot <= '0;
            r_fbase <= '0;
            r_tap <= '0;
            r_fi <= '0;
            r_acc <= '0;
            r_ready_fil <= 1'b0;
            r_valid <= 1'b0;
            r_out <= '0;
        end else begin
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_free);
            r_hd <= r_hd + AW'(w_free);
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_fwr) begin
                r_fcnt <= r_fcnt + FA'(1);
                if (r_fcnt + FA'(1) == r_ftot) r_ready_fil <= 1'b0;
            end
            r_valid <= w_pop;
            if (w_pop) r_out <= w_fifo_dout;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_cfg <= w_cfg;
                    r_ftot <= FA'(w_cfg.fs * w_cfg.n_fil);
                    r_fcnt <= '0;
                    r_ready_fil <= 1'b1;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: r_state <= ST_WAIT;
                ST_WAIT: if (w_mac) begin
                    r_tap <= '0;
                    r_fi <= '0;
                    r_fbase <= '0;
                    r_acc <= '0;
                    r_state <= ST_MAC;
                end
                ST_MAC: begin
                    r_acc <= r_acc + ACW'(w_prod);
                    r_tap <= r_tap + 8'd1;
                    if (r_tap + 8'd1 == r_cfg.fs) r_state <= ST_PUSH;
                end
                ST_PUSH: if (!w_full) begin
                    r_tap <= '0;
                    r_acc <= '0;
                    if (r_fi + 8'd1 == r_cfg.n_fil) r_state <= ST_ADV;
                    else begin
                        r_fi <= r_fi + 8'd1;
                        r_fbase <= r_fbase + FA'(r_cfg.fs);
                        r_state <= ST_MAC;
                    end
                end
                ST_ADV: if (w_adv) r_state <= ST_WAIT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_multi_fil.sv
// tb_pe_multi_fil: directed bench for pe_multi_fil with hand-computed psums.
module tb_pe_multi_fil;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [2:0] stride = '0;
    logic [3:0] filter_size = '0;
    logic [2:0] n_fil = '0;
    logic w_en_ifm = 1'b0;
    logic [17:0] data_in_ifm = '0;
    logic ready_ifm;
    logic w_en_fil = 1'b0;
    logic [15:0] data_in_fil = '0;
    logic ready_fil;
    logic r_en = 1'b0;
    logic [15:0] out;
    logic valid;
    logic done;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0 = 0;
`ifdef PE_SAT_EN
    localparam logic [15:0] SAT_EXP = 16'd32767;
`else
    localparam logic [15:0] SAT_EXP = 16'd2;
`endif

    pe_multi_fil dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .filter_size(filter_size),
        .n_fil(n_fil), .w_en_ifm(w_en_ifm), .data_in_ifm(data_in_ifm), .ready_ifm(ready_ifm),
        .w_en_fil(w_en_fil), .data_in_fil(data_in_fil), .ready_fil(ready_fil),
        .r_en(r_en), .out(out), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, o, e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        w_en_ifm = 1'b0;
        w_en_fil = 1'b0;
        r_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, 32'(out), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rifm"}, 32'(ready_ifm), 32'd0);
        chk({tag, "_rfil"}, 32'(ready_fil), 32'd0);
    endtask

    task automatic cfg(input logic [2:0] s, input logic [3:0] f, input logic [2:0] n);
        stride = s;
        filter_size = f;
        n_fil = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic fil(input logic [15:0] v);
        w_en_fil = 1'b1;
        data_in_fil = v;
        tick();
        w_en_fil = 1'b0;
    endtask

    task automatic wr(input logic [15:0] v, input logic s, input logic e);
        int n = 0;
        w_en_ifm = 1'b1;
        data_in_ifm = {s, e, v};
        while (!ready_ifm && n < 300) begin
            tick();
            n++;
        end
        chk("wr_ready", 32'(ready_ifm), 32'd1);
        tick();
        w_en_ifm = 1'b0;
    endtask

    task automatic row(input int first, input int len);
        for (int i = 0; i < len; i++) wr(16'(first + i), i == 0, i == len - 1);
    endtask

    task automatic pop(input string tag, input logic [15:0] e);
        int n = 0;
        r_en = 1'b1;
        tick();
        while (!valid && n < 300) begin
            tick();
            n++;
        end
        r_en = 1'b0;
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk(tag, 32'(out), 32'(e));
    endtask

    initial begin
        do_reset();
        chk_idle("rst");

        // basic window: stride 1, fs 3, one filter
        cfg(3'd1, 4'd3, 3'd1);
        chk("t1_rfil_hi", 32'(ready_fil), 32'd1);
        chk("t1_rifm_hi", 32'(ready_ifm), 32'd1);
        fil(16'd1);
        fil(16'd2);
        fil(16'd3);
        chk("t1_rfil_lo", 32'(ready_fil), 32'd0);
        stride = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_start_ignored", 32'(ready_fil), 32'd0);
        d0 = done_cnt;
        row(1, 4);
        pop("t1_p0", 16'd14);
        pop("t1_p1", 16'd20);
        repeat (10) tick();
        chk("t1_done", 32'(done_cnt - d0), 32'd1);

        // multi-filter ordering
        do_reset();
        cfg(3'd1, 4'd2, 3'd2);
        fil(16'd1);
        fil(16'd1);
        fil(16'd1);
        fil(16'hFFFF);
        d0 = done_cnt;
        wr(16'd5, 1'b1, 1'b0);
        wr(16'd3, 1'b0, 1'b0);
        wr(16'd2, 1'b0, 1'b1);
        pop("t2_p0", 16'd8);
        pop("t2_p1", 16'd2);
        pop("t2_p2", 16'd5);
        pop("t2_p3", 16'd1);
        repeat (10) tick();
        chk("t2_done", 32'(done_cnt - d0), 32'd1);

        // stride 2 with a discarded tail window
        do_reset();
        cfg(3'd2, 4'd3, 3'd1);
        fil(16'd1);
        fil(16'd1);
        fil(16'd1);
        d0 = done_cnt;
        row(1, 6);
        pop("t3_p0", 16'd6);
        pop("t3_p1", 16'd12);
        repeat (10) tick();
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("t3_no_extra", 32'(valid), 32'd0);
        chk("t3_done", 32'(done_cnt - d0), 32'd1);

        // back-pressure and ifmap wrap: three rows of 7, fs 4, 12 psums
        do_reset();
        cfg(3'd1, 4'd4, 3'd1);
        fil(16'd1);
        fil(16'd2);
        fil(16'd3);
        fil(16'd4);
        d0 = done_cnt;
        row(1, 7);
        row(10, 7);
        row(100, 7);
        repeat (40) tick();
        chk("t4_stall_valid", 32'(valid), 32'd0);
        chk("t4_stall_rifm", 32'(ready_ifm), 32'd1);
        pop("t4_p0", 16'd30);
        pop("t4_p1", 16'd40);
        pop("t4_p2", 16'd50);
        pop("t4_p3", 16'd60);
        pop("t4_p4", 16'd120);
        pop("t4_p5", 16'd130);
        pop("t4_p6", 16'd140);
        pop("t4_p7", 16'd150);
        pop("t4_p8", 16'd1020);
        pop("t4_p9", 16'd1030);
        pop("t4_p10", 16'd1040);
        pop("t4_p11", 16'd1050);
        repeat (10) tick();
        chk("t4_done", 32'(done_cnt - d0), 32'd3);

        // saturation or wrap of a large accumulation
        do_reset();
        cfg(3'd1, 4'd2, 3'd1);
        fil(16'd32767);
        fil(16'd32767);
        wr(16'd32767, 1'b1, 1'b0);
        wr(16'd32767, 1'b0, 1'b1);
        pop("t5_sat", SAT_EXP);

        // reset mid-MAC, then degenerate config
        do_reset();
        cfg(3'd1, 4'd3, 3'd1);
        fil(16'd1);
        fil(16'd1);
        fil(16'd1);
        row(1, 3);
        tick();
        rst_n = 1'b0;
        tick();
        chk_idle("t6_rst");
        rst_n = 1'b1;
        cfg(3'd0, 4'd0, 3'd0);
        chk("t6_rfil_hi", 32'(ready_fil), 32'd1);
        fil(16'd3);
        chk("t6_rfil_lo", 32'(ready_fil), 32'd0);
        wr(16'd4, 1'b1, 1'b0);
        wr(16'd5, 1'b0, 1'b1);
        pop("t6_p0", 16'd12);
        pop("t6_p1", 16'd15);
        repeat (10) tick();
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        chk("t6_empty", 32'(valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
